// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per frame, blocking single-word fill.
// Hits are answered combinationally in IDLE; misses hold in FILL until memory returns the word.
module icache #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [SETS-1:0]   r_valid;
  logic [TW-1:0]     r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic [IW-1:0]     w_req_index;
  logic [TW-1:0]     w_req_tag;
  logic [IW-1:0]     w_fill_index;
  logic [TW-1:0]     w_fill_tag;
  logic              w_start_miss;
  logic              w_fill_done;

  assign w_req_index  = imemaddr[IW+1:2];
  assign w_req_tag    = imemaddr[31:IW+2];
  assign w_fill_index = r_miss_addr[IW+1:2];
  assign w_fill_tag   = r_miss_addr[31:IW+2];

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_comb begin
    w_next_state = r_state;
    ihit         = 1'b0;
    imemload     = 32'd0;
    iREN         = 1'b0;
    iaddr        = 32'd0;
    w_start_miss = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (imemREN) begin
          if (r_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag)) begin
            ihit     = 1'b1;
            imemload = r_data[w_req_index];
          end else begin
            w_start_miss = 1'b1;
            w_next_state = FILL;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      // The fill always targets the latched miss address, whatever the datapath does meanwhile.
      FILL: begin
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        if (!iwait) begin
          w_fill_done  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = FILL;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_start_miss) begin
        r_miss_addr <= {imemaddr[31:2], 2'b00};
      end else begin
        r_miss_addr <= r_miss_addr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_valid <= {SETS{1'b0}};
    end else if (w_fill_done) begin
      r_valid[w_fill_index] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Tag/data arrays are never cleared; the valid bits alone decide whether a frame can hit.
  always_ff @(posedge CLK) begin
    if (w_fill_done && !nRST) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= iload;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_hit_count  <= {CNT_W{1'b0}};
      r_miss_count <= {CNT_W{1'b0}};
    end else begin
      if (ihit && (r_hit_count != CNT_MAX)) begin
        r_hit_count <= r_hit_count + CNT_ONE;
      end else begin
        r_hit_count <= r_hit_count;
      end
      if (w_start_miss && (r_miss_count != CNT_MAX)) begin
        r_miss_count <= r_miss_count + CNT_ONE;
      end else begin
        r_miss_count <= r_miss_count;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a default-size instance plus a CNT_W=4 instance sharing its stimulus.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;
  logic        s_ihit, s_iREN;
  logic [31:0] s_imemload, s_iaddr;
  logic [3:0]  s_hit_count, s_miss_count;

  int checks = 0;
  int errors = 0;
  int exp_hit;
  int exp_miss;

  always #5 CLK = ~CLK;

  icache #(.SETS(16), .CNT_W(32)) u_dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  icache #(.SETS(16), .CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(s_ihit), .imemload(s_imemload), .iREN(s_iREN), .iaddr(s_iaddr),
    .iwait(iwait), .iload(iload), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hits"}, hit_count, exp_hit);
    chk({tag, "_misses"}, miss_count, exp_miss);
  endtask

  task automatic do_reset();
    nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1; iload = 32'd0;
    tick();
    nRST = 1'b0;
    exp_hit = 0; exp_miss = 0;
  endtask

  // Miss on addr, memory busy for 'waits' cycles, then returns data.
  task automatic fill(input logic [31:0] addr, input int waits, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1;
    chk("miss_ihit", {31'd0, ihit}, 32'd0);
    chk("miss_imemload", imemload, 32'd0);
    tick();
    for (int w = 0; w < waits; w++) begin
      chk("fill_iren", {31'd0, iREN}, 32'd1);
      chk("fill_iaddr", iaddr, {addr[31:2], 2'b00});
      chk("fill_ihit", {31'd0, ihit}, 32'd0);
      tick();
    end
    iwait = 1'b0; iload = data;
    #1;
    chk("fill_last_iren", {31'd0, iREN}, 32'd1);
    chk("fill_last_iaddr", iaddr, {addr[31:2], 2'b00});
    tick();
    iwait = 1'b1; iload = 32'd0; imemREN = 1'b0;
    exp_miss++;
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr;
    #1;
    chk("hit_ihit", {31'd0, ihit}, 32'd1);
    chk("hit_imemload", imemload, data);
    chk("hit_iren", {31'd0, iREN}, 32'd0);
    chk("hit_iaddr", iaddr, 32'd0);
    tick();
    imemREN = 1'b0;
    exp_hit++;
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
    exp_hit = 0; exp_miss = 0;
    tick();
    tick();
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    #1;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk_counts("rst");
    imemREN = 1'b0;
    nRST = 1'b0;
    tick();
    chk("post_rst_iren", {31'd0, iREN}, 32'd0);

    // Cold miss with three wait cycles.
    fill(32'h0000_0040, 3, 32'h2001_0005);
    hit(32'h0000_0040, 32'h2001_0005);
    chk_counts("cold");

    // Conflict on index 0: 0x440 evicts 0x40, which then misses again.
    fill(32'h0000_0440, 0, 32'h0BAD_F00D);
    hit(32'h0000_0440, 32'h0BAD_F00D);
    fill(32'h0000_0040, 1, 32'h2001_0005);
    chk("conflict_misses", miss_count, 32'd3);
    hit(32'h0000_0040, 32'h2001_0005);
    chk_counts("conflict");

    // Reset mid-fill aborts it; the same address misses afterwards.
    imemREN = 1'b1; imemaddr = 32'h0000_0020;
    #1;
    chk("rmf_first_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("rmf_fill_iaddr", iaddr, 32'h0000_0020);
    tick();
    nRST = 1'b1; imemREN = 1'b0;
    tick();
    nRST = 1'b0;
    exp_hit = 0; exp_miss = 0;
    chk("rmf_iren", {31'd0, iREN}, 32'd0);
    chk("rmf_iaddr", iaddr, 32'd0);
    chk_counts("rmf");
    fill(32'h0000_0020, 0, 32'h3333_4444);
    hit(32'h0000_0020, 32'h3333_4444);

    // Preload all 16 frames (0x20 already resident), then 16 back-to-back hits.
    for (int i = 0; i < 16; i++) begin
      if (i != 8) fill(32'(i * 4), 0, 32'h1000_0000 + 32'(i));
    end
    imemREN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imemaddr = 32'(i * 4);
      #1;
      chk("seq_ihit", {31'd0, ihit}, 32'd1);
      chk("seq_data", imemload, (i == 8) ? 32'h3333_4444 : 32'h1000_0000 + 32'(i));
      chk("seq_iren", {31'd0, iREN}, 32'd0);
      tick();
    end
    imemREN = 1'b0;
    exp_hit += 16;
    chk_counts("seq");

    // After reset, frame 0 still stores tag 0 but is invalid: address 0 must not hit.
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h0000_0000;
    #1;
    chk("inv_ihit", {31'd0, ihit}, 32'd0);
    chk("inv_imemload", imemload, 32'd0);
    imemREN = 1'b0;
    tick();
    chk("inv_iren", {31'd0, iREN}, 32'd0);

    // Redirect during fill: iaddr stays on 0x80 until the fill completes.
    imemREN = 1'b1; imemaddr = 32'h0000_0080; iwait = 1'b1;
    #1;
    chk("redir_miss", {31'd0, ihit}, 32'd0);
    tick();
    imemaddr = 32'h0000_0100;
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("redir_iren", {31'd0, iREN}, 32'd1);
      chk("redir_iaddr", iaddr, 32'h0000_0080);
      tick();
    end
    imemREN = 1'b0;
    #1;
    chk("redir_nren_iaddr", iaddr, 32'h0000_0080);
    iwait = 1'b0; iload = 32'h8080_8080;
    tick();
    iwait = 1'b1; iload = 32'd0;
    exp_miss++;
    chk("redir_idle_iren", {31'd0, iREN}, 32'd0);
    hit(32'h0000_0080, 32'h8080_8080);
    fill(32'h0000_0100, 1, 32'h0100_0100);
    hit(32'h0000_0100, 32'h0100_0100);
    chk_counts("redir");

    // Saturation of the 4-bit counters after 20 hits.
    do_reset();
    fill(32'h0000_0004, 0, 32'h4444_0004);
    for (int i = 0; i < 20; i++) hit(32'h0000_0004, 32'h4444_0004);
    chk_counts("sat_wide");
    chk("sat_hits", {28'd0, s_hit_count}, 32'h0000_000F);
    chk("sat_misses", {28'd0, s_miss_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter SETS, default 16, number of direct-mapped frames; power of two, 2..64.
REQ-002: Parameter CNT_W, default 32, width of each statistics counter.
REQ-003: CLK  input  1  clock; all state updates on its rising edge.
REQ-004: nRST  input  1  reset; synchronous, active-high (1 = reset), sampled on rising CLK.
REQ-005: imemREN  input  1  datapath fetch request.
REQ-006: imemaddr  input  32  datapath fetch byte address (PC).
REQ-007: ihit  output  1  fetch satisfied this cycle; imemload valid.
REQ-008: imemload  output  32  fetched instruction word.
REQ-009: iREN  output  1  memory read request.
REQ-010: iaddr  output  32  memory read word address.
REQ-011: iwait  input  1  memory busy; iload valid in any cycle where iREN=1 and iwait=0.
REQ-012: iload  input  32  memory read data.
REQ-013: hit_count, miss_count  output  CNT_W each  statistics counters.

Function
REQ-014: Address split: byte offset [1:0] ignored; index = [IW+1:2], IW = log2(SETS); tag = [31:IW+2].
REQ-015: Each frame holds valid bit, tag, one 32-bit data word.
REQ-016: FSM states: IDLE, FILL.
REQ-017: IDLE, imemREN=1, frame[index] valid and tag equal -> ihit=1 and imemload=frame data combinationally, same cycle; remain IDLE.
REQ-018: IDLE, imemREN=1, miss -> ihit=0, latch word-aligned imemaddr as miss_addr, go to FILL next cycle.
REQ-019: IDLE, imemREN=0 -> ihit=0, iREN=0, no state change.
REQ-020: FILL: iREN=1, iaddr=miss_addr, ihit=0, every cycle until fill completes.
REQ-021: FILL with iwait=1 -> remain FILL.
REQ-022: FILL with iwait=0 -> write valid=1, tag and data=iload into frame indexed by miss_addr; return to IDLE next cycle.
REQ-023: Hit after miss: earliest ihit for the missed address is the first IDLE cycle following the fill (miss latency = 1 + memory wait cycles + 1).
REQ-024: Fill in progress always completes to miss_addr even if imemaddr changes or imemREN deasserts during FILL; new address then evaluated in IDLE.
REQ-025: iREN=0 and iaddr=0 whenever not in FILL.
REQ-026: imemload=0 whenever ihit=0.
REQ-027: Fill to a frame holding a different valid tag overwrites it (no write-back; instruction memory read-only here).
REQ-028: hit_count increments by 1 on each cycle with ihit=1; miss_count increments by 1 on each IDLE->FILL transition.
REQ-029: Both counters saturate at all-ones; no wrap.
REQ-030: Cache never asserts ihit for a frame with valid=0, including tag value 0 at address 0.

Reset
REQ-031: nRST=1 at a rising edge -> state IDLE, all valid bits 0, miss_addr 0, hit_count 0, miss_count 0.
REQ-032: During and immediately after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-033: Reset asserted during FILL aborts the fill; no frame written; next post-reset request to same address misses.
REQ-034: Frame tag/data storage need not be cleared on reset; only valid bits.

Verification
REQ-035: Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0x2001_0005 -> iREN=1 iaddr=0x40 for 4 cycles, ihit=1 imemload=0x2001_0005 next cycle; miss_count=1, hit_count=1.
REQ-036: Conflict: fill 0x40 then request 0x0000_0440 (same index 0, SETS=16) -> miss, frame replaced; re-request 0x40 -> misses again; miss_count=3.
REQ-037: Sequential hits: preload 0x00..0x3C (16 words), then request 0x00..0x3C one per cycle -> ihit=1 every cycle, iREN=0 throughout, hit_count +16.
REQ-038: Redirect mid-fill: miss on 0x80, change imemaddr to 0x100 during FILL -> iaddr stays 0x80 until iwait=0, frame 0 holds tag of 0x80, then 0x100 misses separately.
REQ-039: Reset mid-fill: miss on 0x20, assert nRST while iwait=1 -> iREN=0 next cycle, counters 0; request 0x20 again -> miss.
REQ-040: Saturation (CNT_W=4): 20 consecutive hits -> hit_count holds 4'hF.
